// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, sign fix on the last step.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r;
  logic [WIDTH-1:0] acc, q, m;

  // Accept-side operand conditioning
  logic             sgn, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sgn    = ~op[0];
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
  end

  // One iteration: acc is the running high product word / partial remainder,
  // q is the multiplier shifting out / dividend shifting into the quotient.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   acc_nx, q_nx, quo, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    div_shift = {acc, q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_nx = div_diff[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = div_shift[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = mul_sum[WIDTH:1];
      q_nx   = {mul_sum[0], q[WIDTH-1:1]};
    end
    prod = neg_q ? -{acc_nx, q_nx} : {acc_nx, q_nx};
    quo  = neg_q ? -q_nx : q_nx;
    rem  = neg_r ? -acc_nx : acc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nx;
            q   <= q_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (is_div) begin
                hi <= rem;
                lo <= quo;
              end else begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
              end
            end
          end
        end
        default: begin
          // MT* writes land first; a result written later on this edge wins.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          state <= IDLE;
          if (start && !flush) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc    <= '0;
            cnt    <= '0;
            q      <= op[1] ? a_mag : b_mag;
            m      <= op[1] ? b_mag : a_mag;
            if (op[1] && b_zero) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              hi          <= a;
              lo          <= '1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
